wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL take one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 Ports SHALL be:
  clk  in  1  clock; all state updates on posedge
  rst  in  1  asynchronous, active-high reset
  p_valid  in  1  primary (pipeline MEM/WB) write request; cannot be back-pressured
  p_des  in  `RegAddrBus  primary destination register
  p_data  in  `RegDataBus  primary write data
  s_valid  in  1  secondary (multi-cycle unit) write request
  s_ready  out  1  secondary request accepted this cycle when s_valid=1 and s_ready=1
  s_des  in  `RegAddrBus  secondary destination register
  s_data  in  `RegDataBus  secondary write data
  w_write_reg  out  1  register-file write enable (`WriteEnable when active)
  reg_des  out  `RegAddrBus  register-file write address
  reg_data  out  `RegDataBus  register-file write data
  pend_mask  out  `RegNum  bit i set = secondary write to register i not yet committed
  fifo_cnt  out  3  secondary queue occupancy, 0..4
  order_err  out  1  sticky protocol-violation flag

Function
REQ-003 The secondary queue SHALL be a 4-entry FIFO of {des, data}; s_ready SHALL be 1 exactly when fifo_cnt<4; there is no bypass when full.
REQ-004 A handshake with s_des!=0 SHALL push one entry at the clock edge ending that cycle; a handshake with s_des=0 SHALL complete but push nothing.
REQ-005 A primary request with p_des=0 SHALL be treated as no request.
REQ-006 Issue selection per cycle: an effective primary request wins; otherwise the FIFO head issues and is popped if fifo_cnt>0; otherwise nothing issues.
REQ-007 w_write_reg, reg_des and reg_data SHALL be registered; the selected write appears on them for exactly one cycle, the cycle after selection. When nothing issues, w_write_reg=0 and reg_des/reg_data hold their previous values.
REQ-008 Latency: primary request in cycle N -> w_write_reg=1 in cycle N+1. Secondary accepted in cycle N into an empty FIFO with no primary traffic -> w_write_reg=1 in cycle N+2.
REQ-009 Simultaneous push and pop SHALL leave fifo_cnt unchanged; pointers SHALL wrap modulo 4.
REQ-010 FIFO entries SHALL issue strictly in acceptance order.
REQ-011 pend_mask SHALL be the OR of the one-hot decode of every valid FIFO entry's des, plus reg_des while w_write_reg=1 for a secondary-sourced write. The output is combinational from registered state only.
REQ-012 order_err SHALL set, and stay set until reset, when an effective primary request's p_des has its pend_mask bit set in the same cycle. The write still proceeds per REQ-006.
REQ-013 Sustained primary traffic MAY starve the FIFO indefinitely; no fairness is required.

Reset
REQ-014 While rst=1, and immediately on its assertion, the block SHALL hold: w_write_reg=0, reg_des=0, reg_data=0, FIFO empty, pointers=0, fifo_cnt=0, pend_mask=0, order_err=0, s_ready=1.
REQ-015 Reset asserted mid-operation SHALL discard all queued entries and any in-flight output write; no register-file write occurs in the cycle after deassertion.

Structure
REQ-016 Widths `RegAddrBus, `RegDataBus, `RegNum and `WriteEnable SHALL come from macros.v; add `WbFifoDepth (4) and `WbCntBus ([2:0]) there.
REQ-017 The FIFO SHALL be a sub-module wb_fifo (push/pop/full/empty/count, async active-high rst). Arbitration, output register and pend_mask logic stay in wb_arbiter.

Verification
REQ-018 Primary only: p_valid=1, p_des=5, p_data=32'hDEAD_BEEF in cycle 1 -> cycle 2: w_write_reg=1, reg_des=5, reg_data=32'hDEAD_BEEF; cycle 3: w_write_reg=0.
REQ-019 Starve then drain: secondary pushes des 1..4 (data 32'h11..32'h44) over cycles 1-4 while p_valid=1 (p_des=9) through cycle 6 -> fifo_cnt=4 and s_ready=0 in cycle 5; an s_valid in cycle 5 is not accepted; writes to 1,2,3,4 appear in cycles 8-11 in order.
REQ-020 Zero register: p_des=0 with s_valid=1, s_des=0 in the same cycle -> no w_write_reg pulse, fifo_cnt stays 0, handshake completes.
REQ-021 pend_mask/order_err: push s_des=7, then p_valid with p_des=7 while the entry is still queued -> pend_mask[7]=1 until the cycle after the secondary write issues; order_err=1 from the next cycle onward.
REQ-022 Reset mid-flight: 3 queued entries, rst pulsed asynchronously between edges -> all outputs and fifo_cnt=0 immediately; no writes occur after deassertion.
REQ-023 Push/pop same cycle at fifo_cnt=2 with p_valid=0 -> fifo_cnt remains 2 and the head entry issues next cycle.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths, types and helpers for the register-file write-back arbiter.
// The bus-width macros live here so every file of the block sees one definition.
`ifndef WB_ARBITER_MACROS
`define WB_ARBITER_MACROS
`define RegAddrBus  4:0
`define RegDataBus  31:0
`define RegNum      31:0
`define WriteEnable 1'b1
`define WbFifoDepth 4
`define WbCntBus    2:0
`endif

package wb_arbiter_pkg;

    localparam int FIFO_DEPTH = `WbFifoDepth;

    typedef logic [`RegAddrBus] reg_addr_t;
    typedef logic [`RegDataBus] reg_data_t;
    typedef logic [`RegNum]     reg_mask_t;
    typedef logic [`WbCntBus]   cnt_t;
    typedef logic [1:0]         ptr_t;

    typedef struct packed {
        reg_addr_t des;
        reg_data_t data;
    } wb_entry_t;

    function automatic reg_mask_t onehot(input reg_addr_t a);
        reg_mask_t m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Four-entry queue of pending secondary write-backs.
// Exposes per-entry destinations so the arbiter can build its pending mask.
module wb_fifo
    import wb_arbiter_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push_i,
    input  wb_entry_t                       push_entry_i,
    input  logic                            pop_i,
    output wb_entry_t                       head_o,
    output logic                            full_o,
    output logic                            empty_o,
    output cnt_t                            count_o,
    output reg_addr_t [FIFO_DEPTH-1:0]      ent_des_o,
    output logic      [FIFO_DEPTH-1:0]      ent_vld_o
);

    wb_entry_t                 mem_q [FIFO_DEPTH];
    wb_entry_t                 mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     vld_q, vld_d;
    ptr_t                      wptr_q, wptr_d;
    ptr_t                      rptr_q, rptr_d;
    cnt_t                      cnt_q, cnt_d;
    logic                      do_push, do_pop;

    assign full_o  = (cnt_q == cnt_t'(FIFO_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];
    assign ent_vld_o = vld_q;

    // Flatten entry destinations for the pending-mask decode.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_des_o[i] = mem_q[i].des;
        end
    end

    // Next-state: push at write pointer, pop at read pointer, both may coincide.
    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        mem_d   = mem_q;
        vld_d   = vld_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) begin
            mem_d[wptr_q] = push_entry_i;
            vld_d[wptr_q] = 1'b1;
            wptr_d        = wptr_q + 2'd1;
        end
        if (do_pop) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + 2'd1;
        end
        cnt_d = cnt_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end

    // Queue state register; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            vld_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            vld_q  <= vld_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: pipeline writes win, multi-cycle unit
// writes queue up and drain when the pipeline port is idle.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               p_valid,
    input  logic [`RegAddrBus] p_des,
    input  logic [`RegDataBus] p_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [`RegAddrBus] s_des,
    input  logic [`RegDataBus] s_data,
    output logic               w_write_reg,
    output logic [`RegAddrBus] reg_des,
    output logic [`RegDataBus] reg_data,
    output logic [`RegNum]     pend_mask,
    output logic [`WbCntBus]   fifo_cnt,
    output logic               order_err
);

    logic                       p_eff;
    logic                       s_push;
    logic                       s_pop;
    logic                       f_full;
    logic                       f_empty;
    wb_entry_t                  f_head;
    wb_entry_t                  f_in;
    reg_addr_t [FIFO_DEPTH-1:0] f_des;
    logic [FIFO_DEPTH-1:0]      f_vld;

    logic      wr_q, wr_d;
    logic      src_s_q, src_s_d;
    reg_addr_t des_q, des_d;
    reg_data_t data_q, data_d;
    logic      err_q, err_d;

    // Register 0 is hard-wired, so writes to it are dropped at the door.
    assign p_eff   = p_valid && (p_des != '0);
    assign s_ready = !f_full;
    assign s_push  = s_valid && s_ready && (s_des != '0);
    assign s_pop   = !p_eff && !f_empty;
    assign f_in    = '{des: s_des, data: s_data};

    wb_fifo u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (s_push),
        .push_entry_i (f_in),
        .pop_i        (s_pop),
        .head_o       (f_head),
        .full_o       (f_full),
        .empty_o      (f_empty),
        .count_o      (fifo_cnt),
        .ent_des_o    (f_des),
        .ent_vld_o    (f_vld)
    );

    // Pending mask: queued secondary destinations plus one in the output stage.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (f_vld[i]) begin
                pend_mask = pend_mask | onehot(f_des[i]);
            end
        end
        if (wr_q && src_s_q) begin
            pend_mask = pend_mask | onehot(des_q);
        end
    end

    // Issue selection and sticky ordering-violation detection.
    always_comb begin
        wr_d    = 1'b0;
        src_s_d = 1'b0;
        des_d   = des_q;
        data_d  = data_q;
        err_d   = err_q;
        if (p_eff) begin
            wr_d   = `WriteEnable;
            des_d  = p_des;
            data_d = p_data;
            if (pend_mask[p_des]) begin
                err_d = 1'b1;
            end
        end else if (s_pop) begin
            wr_d    = `WriteEnable;
            src_s_d = 1'b1;
            des_d   = f_head.des;
            data_d  = f_head.data;
        end
    end

    // Output write register and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            src_s_q <= 1'b0;
            des_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            src_s_q <= src_s_d;
            des_q   <= des_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign w_write_reg = wr_q;
    assign reg_des     = des_q;
    assign reg_data    = data_q;
    assign order_err   = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for the write-back arbiter.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        p_valid;
    logic [4:0]  p_des;
    logic [31:0] p_data;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_des;
    logic [31:0] s_data;
    logic        w_write_reg;
    logic [4:0]  reg_des;
    logic [31:0] reg_data;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_cnt;
    logic        order_err;

    int n_chk = 0;
    int n_err = 0;

    wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .p_valid     (p_valid),
        .p_des       (p_des),
        .p_data      (p_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_des       (s_des),
        .s_data      (s_data),
        .w_write_reg (w_write_reg),
        .reg_des     (reg_des),
        .reg_data    (reg_data),
        .pend_mask   (pend_mask),
        .fifo_cnt    (fifo_cnt),
        .order_err   (order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid = 1'b0;
        p_des   = '0;
        p_data  = '0;
        s_valid = 1'b0;
        s_des   = '0;
        s_data  = '0;
    endtask

    task automatic chk_reset_state(input string tag);
        check({tag, ".wr"},   w_write_reg, 0);
        check({tag, ".des"},  reg_des, 0);
        check({tag, ".data"}, reg_data, 0);
        check({tag, ".cnt"},  fifo_cnt, 0);
        check({tag, ".pend"}, pend_mask, 0);
        check({tag, ".err"},  order_err, 0);
        check({tag, ".rdy"},  s_ready, 1);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        chk_reset_state("rst0");
        step();
        step();
        rst = 1'b0;
        chk_reset_state("rst1");

        // Primary only
        p_valid = 1'b1; p_des = 5'd5; p_data = 32'hDEAD_BEEF;
        step();
        idle();
        check("p.wr",   w_write_reg, 1);
        check("p.des",  reg_des, 5);
        check("p.data", reg_data, 32'hDEAD_BEEF);
        step();
        check("p.wr0",  w_write_reg, 0);
        check("p.hold", reg_des, 5);

        // Starve then drain
        for (int c = 1; c <= 6; c++) begin
            idle();
            p_valid = 1'b1; p_des = 5'd9; p_data = 32'(c);
            if (c <= 4) begin
                s_valid = 1'b1;
                s_des   = 5'(c);
                s_data  = 32'(c * 'h11);
            end
            if (c == 5) begin
                check("sd.cnt5", fifo_cnt, 4);
                check("sd.rdy5", s_ready, 0);
                s_valid = 1'b1; s_des = 5'd15; s_data = 32'h55;
            end
            step();
        end
        idle();
        check("sd.cnt7",  fifo_cnt, 4);
        check("sd.wr7",   w_write_reg, 1);
        check("sd.des7",  reg_des, 9);
        check("sd.pend7", pend_mask, 32'h1E);
        step();
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("sd.wr%0d", c + 7),   w_write_reg, 1);
            check($sformatf("sd.des%0d", c + 7),  reg_des, c);
            check($sformatf("sd.data%0d", c + 7), reg_data, c * 'h11);
            step();
        end
        check("sd.wr12",  w_write_reg, 0);
        check("sd.cnt12", fifo_cnt, 0);
        check("sd.err",   order_err, 0);

        // Zero register on both ports
        p_valid = 1'b1; p_des = 5'd0; p_data = 32'h1234;
        s_valid = 1'b1; s_des = 5'd0; s_data = 32'h5678;
        check("z.rdy", s_ready, 1);
        step();
        idle();
        check("z.wr",  w_write_reg, 0);
        check("z.cnt", fifo_cnt, 0);
        step();
        check("z.wr2", w_write_reg, 0);

        // Pending mask and ordering error
        s_valid = 1'b1; s_des = 5'd7; s_data = 32'h77;
        step();
        idle();
        check("o.pend1", pend_mask[7], 1);
        check("o.cnt1",  fifo_cnt, 1);
        check("o.err1",  order_err, 0);
        p_valid = 1'b1; p_des = 5'd7; p_data = 32'hAA;
        step();
        idle();
        check("o.err2",  order_err, 1);
        check("o.wr2",   w_write_reg, 1);
        check("o.data2", reg_data, 32'hAA);
        check("o.pend2", pend_mask[7], 1);
        step();
        check("o.des3",  reg_des, 7);
        check("o.data3", reg_data, 32'h77);
        check("o.pend3", pend_mask[7], 1);
        check("o.cnt3",  fifo_cnt, 0);
        step();
        check("o.pend4", pend_mask, 0);
        check("o.err4",  order_err, 1);
        check("o.wr4",   w_write_reg, 0);

        // Push and pop in the same cycle at count 2
        p_valid = 1'b1; p_des = 5'd20; p_data = 32'h20;
        s_valid = 1'b1; s_des = 5'd2;  s_data = 32'h22;
        step();
        p_des = 5'd21; p_data = 32'h21;
        s_des = 5'd3;  s_data = 32'h33;
        step();
        idle();
        s_valid = 1'b1; s_des = 5'd4; s_data = 32'h44;
        check("pp.cnt_b", fifo_cnt, 2);
        step();
        idle();
        check("pp.cnt_a", fifo_cnt, 2);
        check("pp.des",   reg_des, 2);
        check("pp.data",  reg_data, 32'h22);
        step();
        check("pp.des2",  reg_des, 3);
        step();
        check("pp.des3",  reg_des, 4);
        step();
        check("pp.cnt_e", fifo_cnt, 0);

        // Reset in the middle of traffic
        for (int c = 0; c < 3; c++) begin
            p_valid = 1'b1; p_des = 5'd10; p_data = 32'hA0;
            s_valid = 1'b1; s_des = 5'(11 + c); s_data = 32'(c);
            step();
        end
        idle();
        check("rm.cnt", fifo_cnt, 3);
        check("rm.wr",  w_write_reg, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("rm");
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("rm.wr_after%0d", c), w_write_reg, 0);
            check($sformatf("rm.cnt_after%0d", c), fifo_cnt, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
